// File: rtl/camlcd_pkg.sv
// Shared types and constants for the camera/LCD readback path: FSM states,
// packed-word field positions and the black pixel.
package camlcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2,
    ST_HOLD   = 2'd3
  } rb_state_t;

  // Field positions inside each 16-bit FIFO word; bit 15 is padding.
  localparam int B_LSB = 0;
  localparam int C_MSB = 9;
  localparam int G_LSB = 10;
  localparam int G_MSB = 14;

  typedef struct packed {
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
  } rgb30_t;

  localparam rgb30_t BLACK_PIXEL = '0;

endpackage

// File: rtl/rgb30_unpack.sv
// Output stage of the readback pipeline: registers one unpacked 30-bit RGB
// pixel from the FIFO word pair, or black when blank is set.
module rgb30_unpack
  import camlcd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic        blank_i,
  input  logic [15:0] rd1_i,
  input  logic [15:0] rd2_i,
  output logic        valid_o,
  output rgb30_t      pix_o
);

  logic   valid_d, valid_q;
  rgb30_t pix_d, pix_q;
  logic   unused_msbs;

  assign unused_msbs = rd1_i[15] ^ rd2_i[15];

  always_comb begin
    valid_d = valid_i;
    pix_d   = BLACK_PIXEL;
    if (valid_i && !blank_i) begin
      pix_d.r = rd2_i[C_MSB:B_LSB];
      pix_d.g = {rd1_i[G_MSB:G_LSB], rd2_i[G_MSB:G_LSB]};
      pix_d.b = rd1_i[C_MSB:B_LSB];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pix_q   <= BLACK_PIXEL;
    end else begin
      valid_q <= valid_d;
      pix_q   <= pix_d;
    end
  end

  assign valid_o = valid_q;
  assign pix_o   = pix_q;

endmodule

// File: rtl/sdram_pixel_readback.sv
// Pulls packed pixel pairs from the SDRAM read FIFOs at the display's request
// pace. Optional READBACK_STATS_EN adds underflow and frame counters.
module sdram_pixel_readback
  import camlcd_pkg::*;
#(
  parameter int FRAME_PIXELS = 384000,
  parameter int PRIME_LEVEL  = 8,
  parameter int USEDW_W      = 9,
  parameter int CNT_W        = 20
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic               iFrameStart,
  input  logic               iRequest,
  input  logic [15:0]        iRd1_data,
  input  logic [15:0]        iRd2_data,
  input  logic               iRd_empty,
  input  logic [USEDW_W-1:0] iRd_usedw,
  output logic               oRead,
  output logic [9:0]         oRed,
  output logic [9:0]         oGreen,
  output logic [9:0]         oBlue,
  output logic               oValid,
  output logic               oUnderflow,
`ifdef READBACK_STATS_EN
  output logic [15:0]        oUnderflowCnt,
  output logic [15:0]        oFrameCnt,
`endif
  output rb_state_t          oState
);

  // Request/valid contract: every iRequest in cycle t yields exactly one
  // oValid pulse in cycle t+2, with no backpressure in either direction.
  localparam logic [CNT_W-1:0]   FRAME_LIM = CNT_W'(FRAME_PIXELS);
  localparam logic [USEDW_W-1:0] PRIME_LIM = USEDW_W'(PRIME_LEVEL);

  rb_state_t        state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             req_p1_d, req_p1_q;
  logic             rd_p1_d, rd_p1_q;
  logic             underflow_d, underflow_q;
  logic             rd_now;
  logic             uf_event;
  rgb30_t           pix;

  // State register
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; frame start overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (iFrameStart) begin
      state_d = ST_PRIME;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_IDLE;
        ST_PRIME:  if (iRd_usedw >= PRIME_LIM) state_d = ST_STREAM;
        ST_STREAM: if (cnt_d == FRAME_LIM) state_d = ST_HOLD;
        ST_HOLD:   state_d = ST_HOLD;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    rd_now   = iRequest && (state_q == ST_STREAM) && !iRd_empty && !iFrameStart;
    uf_event = iRequest && (state_q == ST_STREAM) && iRd_empty && !iFrameStart;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (iFrameStart)                     cnt_d = '0;
    else if (rd_now && cnt_q != FRAME_LIM) cnt_d = cnt_q + 1'b1;
    underflow_d = iFrameStart ? 1'b0 : (underflow_q | uf_event);
    req_p1_d    = iRequest;
    rd_p1_d     = rd_now;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt_q       <= '0;
      req_p1_q    <= 1'b0;
      rd_p1_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      req_p1_q    <= req_p1_d;
      rd_p1_q     <= rd_p1_d;
      underflow_q <= underflow_d;
    end
  end

  // FIFO data is on the read ports one cycle after the strobe.
  rgb30_unpack u_unpack (
    .clk     (iClk),
    .rst_n   (iRst_n),
    .valid_i (req_p1_q),
    .blank_i (!rd_p1_q),
    .rd1_i   (iRd1_data),
    .rd2_i   (iRd2_data),
    .valid_o (oValid),
    .pix_o   (pix)
  );

  assign oRead      = rd_now;
  assign oRed       = pix.r;
  assign oGreen     = pix.g;
  assign oBlue      = pix.b;
  assign oUnderflow = underflow_q;
  assign oState     = state_q;

`ifdef READBACK_STATS_EN
  logic [15:0] ucnt_d, ucnt_q;
  logic [15:0] fcnt_d, fcnt_q;

  always_comb begin
    ucnt_d = ucnt_q;
    if (iFrameStart)                      ucnt_d = '0;
    else if (uf_event && ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
    fcnt_d = fcnt_q;
    if (state_q == ST_STREAM && state_d == ST_HOLD) fcnt_d = fcnt_q + 16'd1;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      ucnt_q <= '0;
      fcnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign oUnderflowCnt = ucnt_q;
  assign oFrameCnt     = fcnt_q;
`endif

endmodule

// File: tb/tb_sdram_pixel_readback.sv
// Directed bench for sdram_pixel_readback with a 16-pixel frame; covers
// READBACK_STATS_EN outputs when that macro is defined.
module tb_sdram_pixel_readback;
  import camlcd_pkg::*;

  logic        iClk;
  logic        iRst_n;
  logic        iFrameStart;
  logic        iRequest;
  logic [15:0] iRd1_data;
  logic [15:0] iRd2_data;
  logic        iRd_empty;
  logic [8:0]  iRd_usedw;
  logic        oRead;
  logic [9:0]  oRed, oGreen, oBlue;
  logic        oValid;
  logic        oUnderflow;
  rb_state_t   oState;
`ifdef READBACK_STATS_EN
  logic [15:0] oUnderflowCnt;
  logic [15:0] oFrameCnt;
`endif

  int pass_cnt;
  int fail_cnt;
  int total_cnt;
  int reads;

  sdram_pixel_readback #(
    .FRAME_PIXELS (16),
    .PRIME_LEVEL  (8),
    .USEDW_W      (9),
    .CNT_W        (20)
  ) dut (
    .iClk          (iClk),
    .iRst_n        (iRst_n),
    .iFrameStart   (iFrameStart),
    .iRequest      (iRequest),
    .iRd1_data     (iRd1_data),
    .iRd2_data     (iRd2_data),
    .iRd_empty     (iRd_empty),
    .iRd_usedw     (iRd_usedw),
    .oRead         (oRead),
    .oRed          (oRed),
    .oGreen        (oGreen),
    .oBlue         (oBlue),
    .oValid        (oValid),
    .oUnderflow    (oUnderflow),
`ifdef READBACK_STATS_EN
    .oUnderflowCnt (oUnderflowCnt),
    .oFrameCnt     (oFrameCnt),
`endif
    .oState        (oState)
  );

  // Clock / reset
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_pix(input string tag, input logic [9:0] r, input logic [9:0] g,
                           input logic [9:0] b);
    check({tag, "_valid"}, 32'(oValid), 1);
    check({tag, "_r"}, 32'(oRed), 32'(r));
    check({tag, "_g"}, 32'(oGreen), 32'(g));
    check({tag, "_b"}, 32'(oBlue), 32'(b));
  endtask

  // Inputs change 2 time units after the active edge, checks follow 1 unit later.
  task automatic tick();
    @(posedge iClk);
    #2;
  endtask

  task automatic frame_start();
    iFrameStart = 1'b1;
    tick();
    iFrameStart = 1'b0;
  endtask

  initial begin
    pass_cnt = 0; fail_cnt = 0; total_cnt = 0; reads = 0;
    iRst_n = 1'b0; iFrameStart = 1'b0; iRequest = 1'b0;
    iRd1_data = '0; iRd2_data = '0; iRd_empty = 1'b1; iRd_usedw = '0;

    // Reset state
    tick(); tick();
    #1;
    check("rst_valid", 32'(oValid), 0);
    check("rst_read", 32'(oRead), 0);
    check("rst_uf", 32'(oUnderflow), 0);
    check("rst_rgb", {2'b0, oRed, oGreen, oBlue}, 0);
    check("rst_state", 32'(oState), 32'(ST_IDLE));
    iRst_n = 1'b1;
    tick();

    // Priming: low fill keeps PRIME and requests answer black
    iRd_usedw = 9'd3; iRd_empty = 1'b0;
    iRd1_data = 16'h7955; iRd2_data = 16'h16AB;
    frame_start();
    #1 check("prime_state", 32'(oState), 32'(ST_PRIME));
    iRequest = 1'b1;
    #1 check("prime_read", 32'(oRead), 0);
    tick();
    iRequest = 1'b0;
    #1 check("prime_hold", 32'(oState), 32'(ST_PRIME));
    tick();
    #1 check_pix("prime_pix", 10'h0, 10'h0, 10'h0);
    iRd_usedw = 9'd8;
    tick();
    #1 check("stream_state", 32'(oState), 32'(ST_STREAM));

    // Unpack a known pixel
    iRd1_data = '0; iRd2_data = '0;
    iRequest = 1'b1;
    #1 check("t1_read", 32'(oRead), 1);
    tick();
    iRequest = 1'b0;
    iRd1_data = 16'h7955; iRd2_data = 16'h16AB;
    #1 check("t1_valid_early", 32'(oValid), 0);
    tick();
    #1 check_pix("t1_pix", 10'h2AB, 10'h3C5, 10'h155);

    // Underflow in STREAM
    iRequest = 1'b1; iRd_empty = 1'b1;
    #1 check("uf_read", 32'(oRead), 0);
    tick();
    iRequest = 1'b0; iRd_empty = 1'b0;
    #1 check("uf_flag", 32'(oUnderflow), 1);
`ifdef READBACK_STATS_EN
    check("uf_cnt", 32'(oUnderflowCnt), 1);
`endif
    tick();
    #1 check_pix("uf_pix", 10'h0, 10'h0, 10'h0);

    // Full 16-pixel frame with one extra request
    frame_start();
    #1 check("f4_state", 32'(oState), 32'(ST_PRIME));
    check("f4_uf_clr", 32'(oUnderflow), 0);
`ifdef READBACK_STATS_EN
    check("f4_ufcnt_clr", 32'(oUnderflowCnt), 0);
`endif
    tick();
    #1 check("f4_stream", 32'(oState), 32'(ST_STREAM));
    iRd1_data = '0;
    for (int i = 0; i < 19; i++) begin
      iRequest  = (i < 17);
      iRd2_data = 16'(i);
      #1;
      check($sformatf("f4_read%0d", i), 32'(oRead), (i < 16) ? 1 : 0);
      if (oRead) reads++;
      if (i >= 2)
        check_pix($sformatf("f4_pix%0d", i), (i <= 17) ? 10'(i - 1) : 10'h0, 10'h0, 10'h0);
      tick();
    end
    iRequest = 1'b0;
    #1 check("f4_reads", 32'(reads), 16);
    check("f4_hold", 32'(oState), 32'(ST_HOLD));
`ifdef READBACK_STATS_EN
    check("f4_fcnt", 32'(oFrameCnt), 1);
`endif
    frame_start();
    #1 check("f4_reprime", 32'(oState), 32'(ST_PRIME));

    // Frame start together with a request
    tick();
    #1 check("f5_stream", 32'(oState), 32'(ST_STREAM));
    iRd1_data = 16'h7955; iRd2_data = 16'h16AB;
    iRequest = 1'b1; iFrameStart = 1'b1;
    #1 check("f5_read", 32'(oRead), 0);
    tick();
    iRequest = 1'b0; iFrameStart = 1'b0;
    #1 check("f5_state", 32'(oState), 32'(ST_PRIME));
    tick();
    #1 check_pix("f5_pix", 10'h0, 10'h0, 10'h0);
    check("f5_stream2", 32'(oState), 32'(ST_STREAM));

    // Reset with requests in flight
    iRequest = 1'b1; iRd_empty = 1'b1;
    tick();
    iRd_empty = 1'b0; iRd1_data = '0; iRd2_data = '0;
    tick();
    iRd1_data = 16'h7955; iRd2_data = 16'h16AB;
    #1 check("r6_uf", 32'(oUnderflow), 1);
    tick();
    #1 check_pix("r6_pix", 10'h2AB, 10'h3C5, 10'h155);
    iRst_n = 1'b0;
    #1;
    check("r6_valid0", 32'(oValid), 0);
    check("r6_rgb0", {2'b0, oRed, oGreen, oBlue}, 0);
    check("r6_read0", 32'(oRead), 0);
    check("r6_uf0", 32'(oUnderflow), 0);
    check("r6_state", 32'(oState), 32'(ST_IDLE));
    iRequest = 1'b0;
    tick();
    iRst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1 check($sformatf("r6_novalid%0d", i), 32'(oValid), 0);
    end
    check("r6_idle", 32'(oState), 32'(ST_IDLE));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
